snake_body: RTL and testbench

- Stores the snake's body segment coordinates on the game grid and advances them by one cell on each move step.
- Sits directly downstream of the head-update stage. It takes the new head position computed from the direction and push buttons and shifts it into the body.
- Detects wall and self collisions and grows the snake on food.
- Feeds the current head back to the head-update stage and answers per-pixel "is body here" queries from the VGA stage.

---
 rtl/snake_body_if.sv | 39 +++
 rtl/snake_body.sv | 136 +++++++++++++
 tb/tb_snake_body.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_if.sv
// rtl/snake_body_if.sv - step/head/query/status bundle between the game logic and snake_body
//
// Purpose: groups the head-update inputs, the VGA query and the status
//          outputs of snake_body into one interface.
// Ports (signals):
//    i_Step, i_Head_x, i_Head_y, i_Grow : move request from the head-update stage
//    i_Qx, i_Qy                         : per-pixel cell query from the VGA stage
//    o_Head_x/y, o_Tail_x/y, o_Len      : registered snake geometry
//    o_Done, o_Dead, o_Full, o_Q_hit    : step result, collision, full and query result
// Modports: master = driver of steps and queries, slave = snake_body.
interface snake_body_if;
   logic       i_Step;
   logic [5:0] i_Head_x;
   logic [5:0] i_Head_y;
   logic       i_Grow;
   logic [5:0] i_Qx;
   logic [5:0] i_Qy;
   logic [5:0] o_Head_x;
   logic [5:0] o_Head_y;
   logic [5:0] o_Tail_x;
   logic [5:0] o_Tail_y;
   logic [5:0] o_Len;
   logic       o_Done;
   logic       o_Dead;
   logic       o_Full;
   logic       o_Q_hit;

   modport master (
      output i_Step, i_Head_x, i_Head_y, i_Grow, i_Qx, i_Qy,
      input  o_Head_x, o_Head_y, o_Tail_x, o_Tail_y, o_Len,
      input  o_Done, o_Dead, o_Full, o_Q_hit
   );

   modport slave (
      input  i_Step, i_Head_x, i_Head_y, i_Grow, i_Qx, i_Qy,
      output o_Head_x, o_Head_y, o_Tail_x, o_Tail_y, o_Len,
      output o_Done, o_Dead, o_Full, o_Q_hit
   );
endinterface

// File: rtl/snake_body.sv
// rtl/snake_body.sv - snake segment store with move, grow, collision and cell query
//
// Purpose: holds the snake body as a shift register of (x,y) cells, shifts
//          a new head in on every accepted step, grows on food, detects wall
//          and self collisions and answers "is body here" queries.
// Ports:
//    Clk : system clock, rising edge
//    Rst : synchronous active-low reset
//    bus : snake_body_if.slave (step/head/grow in, query in, geometry/status out)
// Configuration macro: SNAKE_WRAP_EN - walls wrap around instead of killing.
module snake_body #(
   parameter int MAX_LEN  = 32,
   parameter int INIT_LEN = 3,
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30,
   parameter int INIT_X   = 10,
   parameter int INIT_Y   = 15
) (
   input logic         Clk,
   input logic         Rst,
   snake_body_if.slave bus
);
   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic {ALIVE, DEAD} state_t;

   state_t     state, state_next;
   logic [5:0] seg_x [MAX_LEN];
   logic [5:0] seg_y [MAX_LEN];
   logic [5:0] len;
   logic       done_q;
   logic       q_hit_q;

   logic [5:0] hx, hy;
   logic       wall_hit, self_hit, g;
   logic       commit, done_next, q_match;
   logic [5:0] tail_idx;

   // Head normalisation: wrap mode folds out-of-range coordinates back
   // onto the grid (63 is "minus one" from the head-update stage).
   always_comb begin
      hx       = bus.i_Head_x;
      hy       = bus.i_Head_y;
      wall_hit = 1'b0;
`ifdef SNAKE_WRAP_EN
      if (bus.i_Head_x == 6'd63)
         hx = 6'(GRID_W - 1);
      else if (bus.i_Head_x >= 6'(GRID_W))
         hx = 6'd0;
      if (bus.i_Head_y == 6'd63)
         hy = 6'(GRID_H - 1);
      else if (bus.i_Head_y >= 6'(GRID_H))
         hy = 6'd0;
`else
      wall_hit = (bus.i_Head_x >= 6'(GRID_W)) || (bus.i_Head_y >= 6'(GRID_H));
`endif
   end

   // Parallel compares against live segments. Without growth the tail
   // vacates its cell this step, so moving onto it is legal.
   always_comb begin
      g        = bus.i_Grow && (len < 6'(MAX_LEN));
      self_hit = 1'b0;
      q_match  = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (6'(k) < len) begin
            if (hx == seg_x[k] && hy == seg_y[k] && !(6'(k) == len - 6'd1 && !g))
               self_hit = 1'b1;
            if (bus.i_Qx == seg_x[k] && bus.i_Qy == seg_y[k])
               q_match = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      commit     = 1'b0;
      done_next  = 1'b0;
      case (state)
         ALIVE: begin
            if (bus.i_Step) begin
               if (wall_hit || self_hit) begin
                  state_next = DEAD;
               end else begin
                  commit    = 1'b1;
                  done_next = 1'b1;
               end
            end
         end
         DEAD: state_next = DEAD;
         default: state_next = DEAD;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst)
         state <= ALIVE;
      else
         state <= state_next;
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= (i < INIT_LEN) ? 6'(INIT_X - i) : 6'd0;
            seg_y[i] <= (i < INIT_LEN) ? 6'(INIT_Y) : 6'd0;
         end
         len     <= 6'(INIT_LEN);
         done_q  <= 1'b0;
         q_hit_q <= 1'b0;
      end else begin
         if (commit) begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
               seg_x[i] <= seg_x[i-1];
               seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= hx;
            seg_y[0] <= hy;
            len      <= len + {5'd0, g};
         end
         done_q  <= done_next;
         q_hit_q <= q_match;
      end
   end

   assign tail_idx     = len - 6'd1;
   assign bus.o_Head_x = seg_x[0];
   assign bus.o_Head_y = seg_y[0];
   assign bus.o_Tail_x = seg_x[tail_idx[IW-1:0]];
   assign bus.o_Tail_y = seg_y[tail_idx[IW-1:0]];
   assign bus.o_Len    = len;
   assign bus.o_Done   = done_q;
   assign bus.o_Dead   = (state == DEAD);
   assign bus.o_Full   = (len == 6'(MAX_LEN));
   assign bus.o_Q_hit  = q_hit_q;
endmodule

// File: tb/tb_snake_body.sv
// tb/tb_snake_body.sv - self-checking bench for snake_body
module tb_snake_body;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   snake_body_if bus ();
   snake_body dut (.Clk(clk), .Rst(rst), .bus(bus));

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   // Model: the snake as a list of cells, head first.
   int  bx[$];
   int  by[$];
   bit  m_dead = 1'b0;
   bit  m_done = 1'b0;
   bit  m_q    = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      int hx, hy, n;
      bit hit, g;
      if (!rst) begin
         bx = {10, 9, 8};
         by = {15, 15, 15};
         m_dead = 0; m_done = 0; m_q = 0;
      end else begin
         m_q = 0;
         foreach (bx[k])
            if (bx[k] == int'(bus.i_Qx) && by[k] == int'(bus.i_Qy)) m_q = 1;
         m_done = 0;
         if (bus.i_Step && !m_dead) begin
            hx = int'(bus.i_Head_x);
            hy = int'(bus.i_Head_y);
            hit = 0;
`ifdef SNAKE_WRAP_EN
            if (hx == 63) hx = 39; else if (hx >= 40) hx = 0;
            if (hy == 63) hy = 29; else if (hy >= 30) hy = 0;
`else
            if (hx >= 40 || hy >= 30) hit = 1;
`endif
            g = bus.i_Grow && (bx.size() < 32);
            n = g ? bx.size() : bx.size() - 1;
            for (int k = 0; k < n; k++)
               if (bx[k] == hx && by[k] == hy) hit = 1;
            if (hit) begin
               m_dead = 1;
            end else begin
               bx.push_front(hx);
               by.push_front(hy);
               if (!g) begin
                  void'(bx.pop_back());
                  void'(by.pop_back());
               end
               m_done = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en && bx.size() > 0) begin
         chk("m_head_x", int'(bus.o_Head_x), bx[0]);
         chk("m_head_y", int'(bus.o_Head_y), by[0]);
         chk("m_tail_x", int'(bus.o_Tail_x), bx[$]);
         chk("m_tail_y", int'(bus.o_Tail_y), by[$]);
         chk("m_len",    int'(bus.o_Len),    bx.size());
         chk("m_done",   int'(bus.o_Done),   int'(m_done));
         chk("m_dead",   int'(bus.o_Dead),   int'(m_dead));
         chk("m_full",   int'(bus.o_Full),   int'(bx.size() == 32));
         chk("m_q_hit",  int'(bus.o_Q_hit),  int'(m_q));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.i_Step = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic step(input int x, input int y, input bit gr);
      @(negedge clk);
      bus.i_Step = 1'b1;
      bus.i_Head_x = 6'(x);
      bus.i_Head_y = 6'(y);
      bus.i_Grow = gr;
      @(negedge clk);
      bus.i_Step = 1'b0;
      bus.i_Grow = 1'b0;
   endtask

   initial begin
      bus.i_Step = 0; bus.i_Head_x = 0; bus.i_Head_y = 0; bus.i_Grow = 0;
      bus.i_Qx = 6'd63; bus.i_Qy = 6'd63;
      do_reset();
      check_en = 1'b1;
      chk("rst_head_x", int'(bus.o_Head_x), 10);
      chk("rst_head_y", int'(bus.o_Head_y), 15);
      chk("rst_tail_x", int'(bus.o_Tail_x), 8);
      chk("rst_len",    int'(bus.o_Len), 3);
      chk("rst_dead",   int'(bus.o_Dead), 0);
      chk("rst_done",   int'(bus.o_Done), 0);
      chk("rst_full",   int'(bus.o_Full), 0);

      bus.i_Qx = 6'd9; bus.i_Qy = 6'd15;
      @(negedge clk);
      chk("q_hit_9_15", int'(bus.o_Q_hit), 1);
      bus.i_Qx = 6'd7;
      @(negedge clk);
      chk("q_hit_7_15", int'(bus.o_Q_hit), 0);
      bus.i_Qx = 6'd10;

      step(11, 15, 0);
      chk("mv_head_x", int'(bus.o_Head_x), 11);
      chk("mv_tail_x", int'(bus.o_Tail_x), 9);
      chk("mv_len",    int'(bus.o_Len), 3);
      chk("mv_done",   int'(bus.o_Done), 1);
      @(negedge clk);
      chk("mv_done_off", int'(bus.o_Done), 0);

      do_reset();
      step(11, 15, 1);
      chk("gr_len",    int'(bus.o_Len), 4);
      chk("gr_tail_x", int'(bus.o_Tail_x), 8);
      step(12, 15, 0);
      chk("gr2_len",    int'(bus.o_Len), 4);
      chk("gr2_tail_x", int'(bus.o_Tail_x), 9);
      step(9, 15, 0);
      chk("tail_ok_dead", int'(bus.o_Dead), 0);
      chk("tail_ok_done", int'(bus.o_Done), 1);
      chk("tail_ok_hx",   int'(bus.o_Head_x), 9);

      do_reset();
      step(11, 15, 1);
      step(12, 15, 0);
      step(9, 15, 1);
      chk("tail_grow_dead", int'(bus.o_Dead), 1);
      chk("tail_grow_done", int'(bus.o_Done), 0);
      chk("tail_grow_hx",   int'(bus.o_Head_x), 12);

      do_reset();
      step(11, 15, 1);
      step(12, 15, 0);
      step(11, 15, 0);
      chk("seg1_dead", int'(bus.o_Dead), 1);

      do_reset();
      step(40, 15, 0);
`ifdef SNAKE_WRAP_EN
      chk("wall_dead", int'(bus.o_Dead), 0);
      chk("wall_hx",   int'(bus.o_Head_x), 0);
`else
      chk("wall_dead", int'(bus.o_Dead), 1);
      chk("wall_hx",   int'(bus.o_Head_x), 10);
      chk("wall_done", int'(bus.o_Done), 0);
      step(11, 15, 0);
      chk("dead_ignore_hx", int'(bus.o_Head_x), 10);
`endif

      do_reset();
      step(11, 15, 0);
      @(negedge clk);
      rst = 1'b0;
      bus.i_Step = 1'b1;
      bus.i_Head_x = 6'd12; bus.i_Head_y = 6'd15;
      @(negedge clk);
      rst = 1'b1;
      bus.i_Step = 1'b0;
      chk("rprio_hx",   int'(bus.o_Head_x), 10);
      chk("rprio_len",  int'(bus.o_Len), 3);
      chk("rprio_done", int'(bus.o_Done), 0);

      do_reset();
      for (int x = 11; x <= 39; x++) step(x, 15, 1);
      chk("full_len", int'(bus.o_Len), 32);
      chk("full_flag", int'(bus.o_Full), 1);
      step(39, 16, 1);
      chk("full_len2",  int'(bus.o_Len), 32);
      chk("full_flag2", int'(bus.o_Full), 1);
      chk("full_tail",  int'(bus.o_Tail_x), 9);
      chk("full_hy",    int'(bus.o_Head_y), 16);

      @(negedge clk);
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
